// File: rtl/fp32_operand_loader.sv
// Byte-serial operand loader for the FP32 ALU core: shifts in operand A then B (MSB byte first),
// captures the opcode at start, and holds the result under a valid/ready handshake.
module fp32_operand_loader #(
    parameter int BYTES_PER_OP   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in,
    input  logic        byte_valid,
    input  logic        start,
    input  logic        opcode,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        op_code,
    output logic        op_valid,
    input  logic        op_ready,
    output logic        busy,
    output logic        err,
    output logic [3:0]  state_out
);

    localparam int CNT_W  = $clog2(BYTES_PER_OP);
    localparam int IDLE_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BYTES_PER_OP - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = (TIMEOUT_CYCLES > 0) ? IDLE_W'(TIMEOUT_CYCLES) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [31:0]         op_a_nxt, op_b_nxt;
    logic                op_code_nxt, err_nxt;
    logic [CNT_W-1:0]    byte_cnt, byte_cnt_nxt;
    logic [IDLE_W-1:0]   idle_cnt, idle_cnt_nxt;
    logic                loading, timeout_hit;

    assign loading = (state == LOAD_A) || (state == LOAD_B);
    // Timeout fires on the idle cycle that brings the count up to TIMEOUT_CYCLES.
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && loading && !byte_valid &&
                         (idle_cnt + 1'b1 >= IDLE_MAX);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_nxt    = state;
        op_a_nxt     = op_a;
        op_b_nxt     = op_b;
        op_code_nxt  = op_code;
        byte_cnt_nxt = byte_cnt;
        idle_cnt_nxt = idle_cnt;
        err_nxt      = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    op_code_nxt  = opcode;
                    byte_cnt_nxt = '0;
                    idle_cnt_nxt = '0;
                    state_nxt    = LOAD_A;
                end
            end
            LOAD_A, LOAD_B: begin
                if (start) begin
                    // Restart wins over a same-cycle byte or timeout: one err pulse, byte dropped.
                    op_code_nxt  = opcode;
                    byte_cnt_nxt = '0;
                    idle_cnt_nxt = '0;
                    err_nxt      = 1'b1;
                    state_nxt    = LOAD_A;
                end else if (byte_valid) begin
                    if (state == LOAD_A) op_a_nxt = {op_a[23:0], in};
                    else                 op_b_nxt = {op_b[23:0], in};
                    idle_cnt_nxt = '0;
                    if (byte_cnt == LAST_BYTE) begin
                        byte_cnt_nxt = '0;
                        state_nxt    = (state == LOAD_A) ? LOAD_B : HOLD;
                    end else begin
                        byte_cnt_nxt = byte_cnt + 1'b1;
                    end
                end else if (TIMEOUT_CYCLES > 0) begin
                    if (idle_cnt != IDLE_MAX) idle_cnt_nxt = idle_cnt + 1'b1;
                    if (timeout_hit) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            HOLD: begin
                if (op_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op_a     <= '0;
            op_b     <= '0;
            op_code  <= 1'b0;
            byte_cnt <= '0;
            idle_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            op_a     <= op_a_nxt;
            op_b     <= op_b_nxt;
            op_code  <= op_code_nxt;
            byte_cnt <= byte_cnt_nxt;
            idle_cnt <= idle_cnt_nxt;
            err      <= err_nxt;
        end
    end

    // Pure decodes of the state register; no input reaches these combinationally.
    assign op_valid  = (state == HOLD);
    assign busy      = (state != IDLE);
    assign state_out = {2'b00, state};

endmodule

// File: tb/tb_fp32_operand_loader.sv
// Directed bench for fp32_operand_loader: a vector table for the main load/handshake path,
// plus hand-written sequences for timeout, restart and mid-load reset.
module tb_fp32_operand_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_byte;
    logic        byte_valid, start, opcode, op_ready;
    logic [31:0] op_a, op_b;
    logic        op_code, op_valid, busy, err;
    logic [3:0]  state_out;

    int tests = 0;
    int fails = 0;

    fp32_operand_loader #(.BYTES_PER_OP(4), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .in(in_byte), .byte_valid(byte_valid), .start(start),
        .opcode(opcode), .op_a(op_a), .op_b(op_b), .op_code(op_code), .op_valid(op_valid),
        .op_ready(op_ready), .busy(busy), .err(err), .state_out(state_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s, o, bv;
        logic [7:0]  b;
        logic        rdy;
        logic [3:0]  st;
        logic        vld;
        logic        chk_ops;
        logic [31:0] a, bb;
        logic        code;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive inputs, advance one clock, settle 1 time unit after the edge.
    task automatic step(input logic s, input logic o, input logic bv, input logic [7:0] b,
                        input logic rdy);
        start = s; opcode = o; byte_valid = bv; in_byte = b; op_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic check_st(input string name, input logic [3:0] st, input logic vld,
                            input logic e);
        check({name, "/state"}, 32'(state_out), 32'(st));
        check({name, "/valid"}, 32'(op_valid), 32'(vld));
        check({name, "/err"},   32'(err), 32'(e));
        check({name, "/busy"},  32'(busy), 32'(st != 4'd0));
    endtask

    task automatic check_ops(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic c);
        check({name, "/op_a"}, op_a, a);
        check({name, "/op_b"}, op_b, b);
        check({name, "/op_code"}, 32'(op_code), 32'(c));
    endtask

    function automatic vec_t mk(input logic s, input logic o, input logic bv,
                                input logic [7:0] b, input logic rdy, input logic [3:0] st,
                                input logic vld, input logic chk);
        vec_t v;
        v.s = s; v.o = o; v.bv = bv; v.b = b; v.rdy = rdy; v.st = st; v.vld = vld;
        v.chk_ops = chk; v.a = 32'h3F80_0000; v.bb = 32'h4000_0000; v.code = 1'b1;
        return v;
    endfunction

    initial begin
        // start with a same-cycle byte (must be dropped), 8 bytes, 5 HOLD cycles with start and
        // byte_valid noise, then op_ready; finally op_ready while IDLE is ignored.
        vecs[0]  = mk(1, 1, 1, 8'hAA, 0, 1, 0, 0);
        vecs[1]  = mk(0, 0, 1, 8'h3F, 0, 1, 0, 0);
        vecs[2]  = mk(0, 0, 1, 8'h80, 0, 1, 0, 0);
        vecs[3]  = mk(0, 0, 1, 8'h00, 0, 1, 0, 0);
        vecs[4]  = mk(0, 0, 1, 8'h00, 0, 2, 0, 0);
        vecs[5]  = mk(0, 0, 1, 8'h40, 0, 2, 0, 0);
        vecs[6]  = mk(0, 0, 1, 8'h00, 0, 2, 0, 0);
        vecs[7]  = mk(0, 0, 1, 8'h00, 0, 2, 0, 0);
        vecs[8]  = mk(0, 0, 1, 8'h00, 0, 3, 1, 1);
        for (int i = 9; i < 14; i++) vecs[i] = mk(1, 0, 1, 8'hFF, 0, 3, 1, 1);
        vecs[14] = mk(0, 0, 0, 8'h00, 1, 0, 0, 1);
        vecs[15] = mk(0, 0, 0, 8'h00, 1, 0, 0, 1);

        rst = 1'b1; start = 0; opcode = 0; byte_valid = 0; in_byte = 0; op_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        check_st("reset", 4'd0, 1'b0, 1'b0);
        check_ops("reset", 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 8'h00, 0);
        check_st("post_reset_idle", 4'd0, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].s, vecs[i].o, vecs[i].bv, vecs[i].b, vecs[i].rdy);
            check_st($sformatf("vec%0d", i), vecs[i].st, vecs[i].vld, 1'b0);
            if (vecs[i].chk_ops) check_ops($sformatf("vec%0d", i), vecs[i].a, vecs[i].bb, vecs[i].code);
        end

        // Timeout: two bytes then silence; abort on the 4th idle cycle, partial op_a retained.
        step(1, 0, 0, 8'h00, 0);
        step(0, 0, 1, 8'h11, 0);
        step(0, 0, 1, 8'h22, 0);
        for (int i = 1; i <= 3; i++) begin
            step(0, 0, 0, 8'h00, 0);
            check_st($sformatf("tmo_idle%0d", i), 4'd1, 1'b0, 1'b0);
        end
        step(0, 0, 0, 8'h00, 0);
        check_st("tmo_abort", 4'd0, 1'b0, 1'b1);
        check("tmo_partial_a", op_a, 32'h0000_1122);
        step(0, 0, 0, 8'h00, 0);
        check_st("tmo_after", 4'd0, 1'b0, 1'b0);

        // Restart after 3 bytes, with a simultaneous byte that must be dropped.
        step(1, 0, 0, 8'h00, 0);
        step(0, 0, 1, 8'h01, 0);
        step(0, 0, 1, 8'h02, 0);
        step(0, 0, 1, 8'h03, 0);
        step(1, 1, 1, 8'hEE, 0);
        check_st("restart", 4'd1, 1'b0, 1'b1);
        step(0, 0, 1, 8'hC0, 0);
        check_st("restart_b1", 4'd1, 1'b0, 1'b0);
        step(0, 0, 1, 8'h49, 0);
        step(0, 0, 1, 8'h0F, 0);
        check_st("restart_b3", 4'd1, 1'b0, 1'b0);
        step(0, 0, 1, 8'hDB, 0);
        check_st("restart_b4", 4'd2, 1'b0, 1'b0);
        step(0, 0, 1, 8'h41, 0);
        step(0, 0, 1, 8'h20, 0);
        step(0, 0, 1, 8'h00, 0);
        step(0, 0, 1, 8'h00, 0);
        check_st("restart_hold", 4'd3, 1'b1, 1'b0);
        check_ops("restart_hold", 32'hC049_0FDB, 32'h4120_0000, 1'b1);
        step(0, 0, 0, 8'h00, 1);
        check_st("restart_done", 4'd0, 1'b0, 1'b0);

        // Restart coinciding with the timeout cycle: one err pulse and a fresh idle count.
        step(1, 0, 0, 8'h00, 0);
        step(0, 0, 1, 8'h55, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 0);
        step(1, 0, 0, 8'h00, 0);
        check_st("restart_vs_tmo", 4'd1, 1'b0, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            step(0, 0, 0, 8'h00, 0);
            check_st($sformatf("rvt_idle%0d", i), 4'd1, 1'b0, 1'b0);
        end
        step(0, 0, 0, 8'h00, 0);
        check_st("rvt_abort", 4'd0, 1'b0, 1'b1);

        // Asynchronous reset while LOAD_B byte 2 is on the bus, then a clean load.
        step(1, 1, 0, 8'h00, 0);
        step(0, 0, 1, 8'h12, 0);
        step(0, 0, 1, 8'h34, 0);
        step(0, 0, 1, 8'h56, 0);
        step(0, 0, 1, 8'h78, 0);
        step(0, 0, 1, 8'h9A, 0);
        in_byte = 8'hBC;
        rst = 1'b1;
        #1;
        check_st("async_rst", 4'd0, 1'b0, 1'b0);
        check_ops("async_rst", 32'h0, 32'h0, 1'b0);
        byte_valid = 0;
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 0, 8'h00, 0);
        step(0, 0, 1, 8'h3F, 0);
        step(0, 0, 1, 8'h80, 0);
        step(0, 0, 1, 8'h00, 0);
        step(0, 0, 1, 8'h00, 0);
        step(0, 0, 1, 8'h40, 0);
        step(0, 0, 1, 8'h00, 0);
        step(0, 0, 1, 8'h00, 0);
        check_st("rst_reload_b3", 4'd2, 1'b0, 1'b0);
        step(0, 0, 1, 8'h00, 0);
        check_st("rst_reload", 4'd3, 1'b1, 1'b0);
        check_ops("rst_reload", 32'h3F80_0000, 32'h4000_0000, 1'b0);
        step(0, 0, 0, 8'h00, 1);
        check_st("rst_reload_done", 4'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
